// File: rtl/dist_ram_fifo_ctrl_pkg.sv
// Shared constants for the distributed-RAM FIFO controller: counter widths,
// stall watchdog limit and bit positions of the packed status flags.
package dist_ram_fifo_ctrl_pkg;

  // Stall watchdog saturation value; ovf_err sets when a stall persists past it.
  localparam logic [7:0] STALL_LIMIT = 8'd255;

  // Bit positions inside the registered status vector.
  localparam int FLAG_FULL   = 0;
  localparam int FLAG_EMPTY  = 1;
  localparam int FLAG_AFULL  = 2;
  localparam int FLAG_AEMPTY = 3;
  localparam int FLAG_OVF    = 4;
  localparam int NUM_FLAGS   = 5;

  // Occupancy must hold 0..DEPTH inclusive, hence one bit wider than an address.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/dist_ram_fifo_ctrl_if.sv
// Producer/consumer valid-ready bundle for the FIFO controller.
// slave: the FIFO side. master: whoever produces into and consumes from it.
interface dist_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dist_ram_fifo_mem.sv
// Distributed simple-dual-port RAM in the configuration the FIFO needs:
// one clock for both ports, synchronous write, asynchronous read with no
// output register, and no initial contents (storage is never reset).
module dist_ram_fifo_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  // Write port: word lands on the same edge the push is accepted.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // Read port is combinational so a freshly written head falls through next cycle.
  assign rd_data = ram[rd_addr];

endmodule

// File: rtl/dist_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller on a distributed RAM.
// Owns pointers, occupancy, registered status flags and a stall watchdog;
// handshake readiness is derived only from registered flags.
module dist_ram_fifo_ctrl
  import dist_ram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  dist_ram_fifo_ctrl_if.slave                bus,
  output logic [cnt_width(ADDR_WIDTH)-1:0]   count,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic                               ovf_err
);

  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [NUM_FLAGS-1:0] RST_FLAGS =
    NUM_FLAGS'((1 << FLAG_EMPTY) | (1 << FLAG_AEMPTY));

  if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10) begin : g_bad_addr_width
    $error("dist_ram_fifo_ctrl: ADDR_WIDTH %0d outside 4..10", ADDR_WIDTH);
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("dist_ram_fifo_ctrl: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $error("dist_ram_fifo_ctrl: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic [NUM_FLAGS-1:0]  flags_q;
  logic [NUM_FLAGS-1:0]  flags_nxt;
  logic [7:0]            stall_cnt;
  logic                  push;
  logic                  pop;
  logic                  stalled;
  logic                  ovf_set;

  assign bus.s_ready = ~flags_q[FLAG_FULL];
  assign bus.m_valid = ~flags_q[FLAG_EMPTY];

  assign push    = bus.s_valid & bus.s_ready;
  assign pop     = bus.m_valid & bus.m_ready;
  // A flush cycle is not a stall; the stall window restarts after it.
  assign stalled = bus.s_valid & flags_q[FLAG_FULL] & ~flush;
  assign ovf_set = stalled & (stall_cnt == STALL_LIMIT);

  // Next occupancy: flush wins, then push/pop net change.
  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // Flags come from next-count so they line up with the registered count.
  always_comb begin
    flags_nxt              = '0;
    flags_nxt[FLAG_FULL]   = (count_nxt == CW'(DEPTH));
    flags_nxt[FLAG_EMPTY]  = (count_nxt == '0);
    flags_nxt[FLAG_AFULL]  = (count_nxt >= CW'(AF_LEVEL));
    flags_nxt[FLAG_AEMPTY] = (count_nxt <= CW'(AE_LEVEL));
    flags_nxt[FLAG_OVF]    = flags_q[FLAG_OVF] | ovf_set;
  end

  // Pointer, count, flag and watchdog state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      flags_q   <= RST_FLAGS;
      stall_cnt <= '0;
    end else begin
      count_q <= count_nxt;
      flags_q <= flags_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        end
      end
      if (!stalled) begin
        stall_cnt <= '0;
      end else if (stall_cnt != STALL_LIMIT) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end

  dist_ram_fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we      (push & ~flush),
    .wr_addr (wr_ptr),
    .wr_data (bus.s_data),
    .rd_addr (rd_ptr),
    .rd_data (bus.m_data)
  );

  assign count        = count_q;
  assign full         = flags_q[FLAG_FULL];
  assign empty        = flags_q[FLAG_EMPTY];
  assign almost_full  = flags_q[FLAG_AFULL];
  assign almost_empty = flags_q[FLAG_AEMPTY];
  assign ovf_err      = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_dist_ram_fifo_ctrl.sv
// Directed bench for dist_ram_fifo_ctrl with a queue scoreboard and a small
// reference model of occupancy, flags and the stall watchdog.
module tb_dist_ram_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          ovf_err;

  dist_ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  dist_ram_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb_q[$];
  int            mstall = 0;
  bit            movf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    int c;
    c = sb_q.size();
    check("count",        32'(count),        32'(c));
    check("full",         32'(full),         32'(c == DEPTH));
    check("empty",        32'(empty),        32'(c == 0));
    check("almost_full",  32'(almost_full),  32'(c >= AF));
    check("almost_empty", 32'(almost_empty), 32'(c <= AE));
    check("s_ready",      32'(bus.s_ready),  32'(c != DEPTH));
    check("m_valid",      32'(bus.m_valid),  32'(c != 0));
    check("ovf_err",      32'(ovf_err),      32'(movf));
  endtask

  // Drive one cycle of stimulus (called #1 after a rising edge), update the
  // model, then check status #1 after the next rising edge.
  task automatic cycle(input logic sv, input logic [DW-1:0] d, input logic mr, input logic fl);
    bit fullm;
    bit do_push;
    bit do_pop;
    fullm       = (sb_q.size() == DEPTH);
    bus.s_valid = sv;
    bus.s_data  = d;
    bus.m_ready = mr;
    flush       = fl;
    do_push     = sv && !fullm && !fl;
    do_pop      = mr && (sb_q.size() > 0) && !fl;
    if (do_pop) begin
      check("m_data", 32'(bus.m_data), 32'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (fl) sb_q.delete();
    if (do_push) sb_q.push_back(d);
    if (fl) begin
      mstall = 0;
    end else if (sv && fullm) begin
      if (mstall == 255) movf = 1'b1;
      else mstall++;
    end else begin
      mstall = 0;
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset then idle, releasing reset mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_status();
    @(posedge clk);
    #1;
    check_status();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill 0x00..0x0F, then drain in order.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Concurrent push/pop at count 8 across two pointer wraps.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // At full, push and pop together: only the pop happens.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 5 with a coincident push of 0xAA.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Stall watchdog: hold s_valid while full for 256 cycles.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) cycle(1'b1, 8'hCC, 1'b0, 1'b0);
    check("ovf_before_256", 32'(ovf_err), 32'(0));
    cycle(1'b1, 8'hCC, 1'b0, 1'b0);
    check("ovf_at_256", 32'(ovf_err), 32'(1));
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Async reset mid-transfer: word in flight is lost, ovf_err clears.
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    movf   = 1'b0;
    mstall = 0;
    check_status();
    @(posedge clk);
    #1;
    check_status();
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_status();
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
